inv_key_schedule: RTL and testbench



---
 rtl/inv_key_schedule_pkg.sv | 34 +++
 rtl/inv_key_schedule_if.sv | 24 ++
 rtl/inv_key_schedule_sub_word.sv | 34 +++
 rtl/inv_key_schedule.sv | 132 +++++++++++++
 tb/tb_inv_key_schedule.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inv_key_schedule_pkg.sv
// Shared types and helpers for the reverse AES key schedule.
// Holds the controller state encoding, the round-constant table and the Nk->Nr relation.
package inv_key_schedule_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        EMIT,
        DONE
    } state_t;

    function automatic int nr(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] j);
        logic [7:0] v;
        case (j)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Request / round-key stream bundle between the key scheduler and its neighbours.
// master drives start/last_key/rk_ready; slave (the scheduler) drives the rest.
interface inv_key_schedule_if #(
    parameter int NK = 4
) ();
    logic              start;
    logic [32*NK-1:0]  last_key;
    logic              busy;
    logic              rk_valid;
    logic              rk_ready;
    logic [127:0]      rk;
    logic [3:0]        rk_round;
    logic              done;

    modport master (
        output start, last_key, rk_ready,
        input  busy, rk_valid, rk, rk_round, done
    );

    modport slave (
        input  start, last_key, rk_ready,
        output busy, rk_valid, rk, rk_round, done
    );
endinterface

// File: rtl/inv_key_schedule_sub_word.sv
// SubWord: four forward AES S-box lookups on one 32-bit word.
// The reverse schedule still needs the forward S-box because it undoes an XOR, not a SubBytes.
module inv_key_schedule_sub_word (
    input  logic [31:0] word,
    output logic [31:0] sub
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the MSBs, so entry b starts at bit (255-b)*8 = {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX[base +: 8];
    endfunction

    assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
endmodule

// File: rtl/inv_key_schedule.sv
// Reverse AES key schedule: loads the last Nk expanded-key words and walks the
// expansion backwards one word per cycle, streaming round keys Nr..0.
//
// state | meaning
// IDLE  | waiting for start
// GEN   | regenerating one earlier word per cycle into the window
// EMIT  | round key r presented, waiting for rk_ready
// DONE  | one-cycle done pulse, then back to IDLE
module inv_key_schedule
    import inv_key_schedule_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst,
    inv_key_schedule_if.slave bus
);
    localparam int NR     = nr(NK);
    localparam int L_INIT = 4 * (NR + 1) - NK;

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $fatal(1, "inv_key_schedule: NK must be 4, 6 or 8");
    end

    state_t      state;
    logic [31:0] win [NK];
    logic [5:0]  l_idx;
    logic [3:0]  r_idx;

    logic [5:0]  h_idx;
    logic [5:0]  h_mod;
    logic [3:0]  rcon_idx;
    logic [31:0] sw_in;
    logic [31:0] sw_out;
    logic [31:0] t_word;
    logic [31:0] new_word;
    logic [5:0]  l_dec;
    logic [3:0]  r_dec;
    logic        hs;

    // Undo w[H] = w[L-1] ^ t(w[H-1]) with i = H; win[0] holds w[L].
    assign h_idx    = l_idx + 6'(NK - 1);
    assign h_mod    = h_idx % 6'(NK);
    assign rcon_idx = 4'(h_idx / 6'(NK));
    assign sw_in    = (h_mod == 6'd0) ? {win[NK-2][23:0], win[NK-2][31:24]} : win[NK-2];

    inv_key_schedule_sub_word u_sub_word (
        .word (sw_in),
        .sub  (sw_out)
    );

    always_comb begin
        t_word = win[NK-2];
        if (h_mod == 6'd0) begin
            t_word = sw_out ^ {rcon(rcon_idx), 24'h000000};
        end else if (NK == 8 && h_mod == 6'd4) begin
            t_word = sw_out;
        end
    end

    assign new_word = win[NK-1] ^ t_word;
    assign l_dec    = l_idx - 6'd1;
    assign r_dec    = r_idx - 4'd1;
    assign hs       = bus.rk_valid && bus.rk_ready;

    // rk is loaded on every entry into EMIT; the selected key always starts at
    // window offset 0 except right after load, where it is the top four words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            l_idx        <= '0;
            r_idx        <= '0;
            for (int k = 0; k < NK; k++) win[k] <= '0;
            bus.busy     <= 1'b0;
            bus.rk_valid <= 1'b0;
            bus.done     <= 1'b0;
            bus.rk       <= '0;
            bus.rk_round <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < NK; k++) win[k] <= bus.last_key[32*(NK-1-k) +: 32];
                        l_idx        <= 6'(L_INIT);
                        r_idx        <= 4'(NR);
                        bus.rk       <= bus.last_key[127:0];
                        bus.rk_round <= 4'(NR);
                        bus.rk_valid <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= EMIT;
                    end
                end
                GEN: begin
                    win[0] <= new_word;
                    for (int k = 1; k < NK; k++) win[k] <= win[k-1];
                    l_idx <= l_dec;
                    if (l_dec == {r_idx, 2'b00}) begin
                        bus.rk       <= {new_word, win[0], win[1], win[2]};
                        bus.rk_round <= r_idx;
                        bus.rk_valid <= 1'b1;
                        state        <= EMIT;
                    end
                end
                EMIT: begin
                    if (hs) begin
                        if (r_idx == 4'd0) begin
                            bus.rk_valid <= 1'b0;
                            bus.done     <= 1'b1;
                            state        <= DONE;
                        end else begin
                            r_idx <= r_dec;
                            if ({r_dec, 2'b00} >= l_idx) begin
                                bus.rk       <= {win[0], win[1], win[2], win[3]};
                                bus.rk_round <= r_dec;
                                state        <= EMIT;
                            end else begin
                                bus.rk_valid <= 1'b0;
                                state        <= GEN;
                            end
                        end
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: a forward FIPS-197 key expansion (S-box
// derived from GF(2^8) inverse + affine map) predicts every round key, a monitor checks.
module tb_inv_key_schedule;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    logic rnd_ready = 1'b0;

    inv_key_schedule_if #(.NK(4)) if4 ();
    inv_key_schedule_if #(.NK(6)) if6 ();
    inv_key_schedule_if #(.NK(8)) if8 ();

    inv_key_schedule #(.NK(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    inv_key_schedule #(.NK(6)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));
    inv_key_schedule #(.NK(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    typedef struct packed {
        logic         busy;
        logic         valid;
        logic         ready;
        logic         done;
        logic [3:0]   round;
        logic [127:0] rk;
    } obs_t;

    obs_t obs [3];
    assign obs[0] = {if4.busy, if4.rk_valid, if4.rk_ready, if4.done, if4.rk_round, if4.rk};
    assign obs[1] = {if6.busy, if6.rk_valid, if6.rk_ready, if6.done, if6.rk_round, if6.rk};
    assign obs[2] = {if8.busy, if8.rk_valid, if8.rk_ready, if8.done, if8.rk_round, if8.rk};

    // ---------------- reference model ----------------
    logic [7:0]  sb [256];
    logic [31:0] wexp [60];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int k = 0; k < nk; k++) wexp[k] = key[255-32*k -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = wexp[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            wexp[i] = wexp[i-nk] ^ t;
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [131:0] q4 [$];
    logic [131:0] q6 [$];
    logic [131:0] q8 [$];

    function automatic void q_push(input int i, input logic [131:0] v);
        case (i)
            0:       q4.push_back(v);
            1:       q6.push_back(v);
            default: q8.push_back(v);
        endcase
    endfunction

    function automatic logic [131:0] q_pop(input int i);
        case (i)
            0:       return q4.pop_front();
            1:       return q6.pop_front();
            default: return q8.pop_front();
        endcase
    endfunction

    function automatic int q_size(input int i);
        case (i)
            0:       return q4.size();
            1:       return q6.size();
            default: return q8.size();
        endcase
    endfunction

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    int           start_cyc [3];
    int           done_cnt  [3];
    int           done_cyc  [3];
    int           hs_cyc    [3][16];
    logic         done_exp  [3];
    logic         stall     [3];
    logic [3:0]   st_round  [3];
    logic [127:0] st_rk     [3];
    logic [127:0] rk_first  [3];
    logic [127:0] rk_last   [3];

    task automatic mon(input int i);
        obs_t o = obs[i];
        logic [131:0] e;
        if (stall[i]) check("hold", {o.valid, o.round, o.rk}, {1'b1, st_round[i], st_rk[i]});
        if (o.done || done_exp[i]) check("done_pulse", o.done, done_exp[i]);
        if (o.done) begin
            done_cnt[i]++;
            done_cyc[i] = cyc - start_cyc[i];
        end
        done_exp[i] = 1'b0;
        if (o.valid && o.ready) begin
            if (q_size(i) == 0) begin
                n_checks++;
                $display("FAIL extra_key: got round %0d rk %h, none expected", o.round, o.rk);
            end else begin
                e = q_pop(i);
                check("round_key", {o.round, o.rk}, e);
                hs_cyc[i][o.round] = cyc - start_cyc[i];
                if (int'(o.round) == 10 + 2 * i) rk_first[i] = o.rk;
                if (o.round == 4'd0) begin
                    done_exp[i] = 1'b1;
                    rk_last[i]  = o.rk;
                end
            end
        end
        stall[i]    = o.valid && !o.ready;
        st_round[i] = o.round;
        st_rk[i]    = o.rk;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                stall[i]    = 1'b0;
                done_exp[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) mon(i);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic s, input logic [255:0] lk);
        case (i)
            0: begin if4.start = s; if4.last_key = lk[255 -: 128]; end
            1: begin if6.start = s; if6.last_key = lk[255 -: 192]; end
            default: begin if8.start = s; if8.last_key = lk; end
        endcase
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_run(input int i, input logic [255:0] key);
        int nk = 4 + 2 * i;
        int nrr = nk + 6;
        logic [255:0] lk = '0;
        expand(nk, key);
        for (int k = 0; k < nk; k++) lk[255-32*k -: 32] = wexp[4*(nrr+1)-nk+k];
        for (int r = nrr; r >= 0; r--)
            q_push(i, {4'(r), wexp[4*r], wexp[4*r+1], wexp[4*r+2], wexp[4*r+3]});
        done_cnt[i] = 0;
        for (int r = 0; r < 16; r++) hs_cyc[i][r] = -1;
        set_in(i, 1'b1, lk);
        start_cyc[i] = cyc;
        tick();
        set_in(i, 1'b0, lk);
    endtask

    task automatic wait_done(input int i);
        int g = 0;
        while (done_cnt[i] == 0 && g < 3000) begin
            tick();
            g++;
        end
        if (done_cnt[i] == 0) begin
            n_checks++;
            $display("FAIL done_timeout: nk=%0d no done within %0d cycles", 4 + 2 * i, g);
        end
        check("keys_left", q_size(i), 0);
    endtask

    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK0    = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        if4.rk_ready = 1'b1;
        if6.rk_ready = 1'b1;
        if8.rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if4.rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if6.rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if8.rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        logic [255:0] junk;
        for (int i = 0; i < 3; i++) set_in(i, 1'b0, '0);
        build_sbox();
        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            check("reset_outputs", {obs[i].busy, obs[i].valid, obs[i].done, obs[i].round, obs[i].rk}, '0);
        rst = 1'b0;
        tick();

        // FIPS C.1, stream never stalled
        start_run(0, KEY_C1);
        wait_done(0);
        check("nk4_first_rk", rk_first[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("nk4_first_cycle", hs_cyc[0][10], 1);
        check("nk4_round0_cycle", hs_cyc[0][0], 51);
        check("nk4_done_cycle", done_cyc[0], 52);
        check("nk4_last_rk", rk_last[0], RK0);

        // FIPS C.2 with start pulses while busy and in the DONE cycle
        start_run(1, KEY_C2);
        while (cyc - start_cyc[1] < 61) begin
            g = cyc - start_cyc[1];
            junk = rand_key();
            set_in(1, (g == 3 || g == 20 || g == 40 || g == 60), junk);
            tick();
        end
        set_in(1, 1'b0, junk);
        check("nk6_ignored_start_idle", obs[1].busy, 1'b0);
        check("nk6_done_count", done_cnt[1], 1);
        check("nk6_keys_left", q_size(1), 0);
        check("nk6_r12_cycle", hs_cyc[1][12], 1);
        check("nk6_r11_cycle", hs_cyc[1][11], 4);
        check("nk6_r10_cycle", hs_cyc[1][10], 9);
        check("nk6_done_cycle", done_cyc[1], 60);
        check("nk6_last_rk", rk_last[1], RK0);
        tick();

        // FIPS C.3, then a back-to-back random run
        start_run(2, KEY_C3);
        wait_done(2);
        check("nk8_r14_cycle", hs_cyc[2][14], 1);
        check("nk8_r13_cycle", hs_cyc[2][13], 2);
        check("nk8_r12_cycle", hs_cyc[2][12], 7);
        check("nk8_done_cycle", done_cyc[2], 68);
        check("nk8_last_rk", rk_last[2], RK0);
        start_run(2, rand_key());
        wait_done(2);
        check("b2b_first_cycle", hs_cyc[2][14], 1);

        // random backpressure with known and random keys
        rnd_ready = 1'b1;
        start_run(0, KEY_C1);
        wait_done(0);
        check("bp_last_rk", rk_last[0], RK0);
        for (int n = 0; n < 3; n++) begin
            start_run(0, rand_key());
            wait_done(0);
        end
        for (int n = 0; n < 2; n++) begin
            start_run(1, rand_key());
            wait_done(1);
            start_run(2, rand_key());
            wait_done(2);
        end
        rnd_ready = 1'b0;
        tick();

        // reset while regenerating words for round 5
        start_run(0, rand_key());
        g = 0;
        while (hs_cyc[0][6] < 0 && g < 200) begin
            tick();
            g++;
        end
        check("pre_reset_busy", obs[0].busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {obs[0].busy, obs[0].valid, obs[0].done, obs[0].round, obs[0].rk}, '0);
        tick();
        rst = 1'b0;
        while (q_size(0) > 0) void'(q_pop(0));
        tick();
        start_run(0, rand_key());
        wait_done(0);
        check("after_reset_first_cycle", hs_cyc[0][10], 1);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
